// File: rtl/clk_sel_ctrl.sv
// Clock-select controller: round-robin arbitration among three requesters, then a
// registered sel_clk switch with a fixed settle time before the requester is acknowledged.
module clk_sel_ctrl #(
  parameter int SETTLE_CYC = 8
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [5:0] tgt,
  output logic [1:0] sel_clk,
  output logic [2:0] ack,
  output logic [2:0] err,
  output logic       busy,
  output logic [1:0] last_grant
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SETTLE,
    RESP,
    WAIT_DROP
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t     state_q, state_d;
  logic [1:0] sel_clk_q, sel_clk_d;
  logic [2:0] ack_q, ack_d;
  logic [2:0] err_q, err_d;
  logic       busy_q, busy_d;
  logic [1:0] last_grant_q, last_grant_d;
  logic [3:0] cnt_q, cnt_d;

  logic [1:0] rr_winner;
  logic [1:0] win_tgt;
  logic [2:0] win_onehot;

  // Search starts one past the last grant so every requester gets a turn.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] cand;
    logic       found;
    rr_pick = 2'd0;
    found   = 1'b0;
    cand    = (last == 2'd2) ? 2'd0 : last + 2'd1;
    for (int i = 0; i < 3; i++) begin
      if (!found && r[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  endfunction

  always_comb begin
    rr_winner  = rr_pick(req, last_grant_q);
    win_onehot = 3'(3'b001 << last_grant_q);
    case (last_grant_q)
      2'd0:    win_tgt = tgt[1:0];
      2'd1:    win_tgt = tgt[3:2];
      default: win_tgt = tgt[5:4];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    sel_clk_d    = sel_clk_q;
    ack_d        = 3'b000;
    err_d        = 3'b000;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          last_grant_d = rr_winner;
          state_d      = CHECK;
        end
      end
      CHECK: begin
        if (win_tgt == 2'b11) begin
          err_d   = win_onehot;
          state_d = RESP;
        end else if (win_tgt == sel_clk_q) begin
          ack_d   = win_onehot;
          state_d = RESP;
        end else begin
          sel_clk_d = win_tgt;
          cnt_d     = SETTLE_LOAD;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        // The ack is registered on the same edge that enters RESP, so it lines up with that state.
        if (cnt_q == 4'd0) begin
          ack_d   = win_onehot;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (!req[last_grant_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_clk_q    <= 2'b00;
      ack_q        <= 3'b000;
      err_q        <= 3'b000;
      busy_q       <= 1'b0;
      last_grant_q <= 2'd2;
      cnt_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      sel_clk_q    <= sel_clk_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign sel_clk    = sel_clk_q;
  assign ack        = ack_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed self-checking bench for clk_sel_ctrl; expected values are hand-derived
// from the edge-by-edge timing of the controller with SETTLE_CYC = 8.
module tb_clk_sel_ctrl;

  localparam int SETTLE_CYC = 8;

  logic       clk1;
  logic       rst_n;
  logic [2:0] req;
  logic [5:0] tgt;
  logic [1:0] sel_clk;
  logic [2:0] ack;
  logic [2:0] err;
  logic       busy;
  logic [1:0] last_grant;

  int tests_run;
  int tests_failed;

  clk_sel_ctrl #(.SETTLE_CYC(SETTLE_CYC)) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .req        (req),
    .tgt        (tgt),
    .sel_clk    (sel_clk),
    .ack        (ack),
    .err        (err),
    .busy       (busy),
    .last_grant (last_grant)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1ns past the last one before sampling.
  task automatic tick(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] new_req, input logic [5:0] new_tgt);
    req = new_req;
    tgt = new_tgt;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(3'b000, 6'b000000);
    tick(2);
    checkOutput("rst_sel", 32'(sel_clk), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_lg", 32'(last_grant), 32'd2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // From IDLE with req already applied: E0 grant, E1 check, optional settle, response, WAIT_DROP.
  task automatic runSwitch(input logic [1:0] exp_lg, input logic [1:0] exp_sel,
                           input logic [2:0] exp_ack, input logic [2:0] exp_err,
                           input bit settles);
    tick(1);
    checkOutput("e0_lg", 32'(last_grant), 32'(exp_lg));
    checkOutput("e0_busy", 32'(busy), 32'd1);
    tick(1);
    checkOutput("e1_sel", 32'(sel_clk), 32'(exp_sel));
    if (settles) begin
      checkOutput("e1_ack_idle", 32'(ack), 32'd0);
      tick(SETTLE_CYC - 1);
      checkOutput("pre_ack", 32'(ack), 32'd0);
      checkOutput("pre_busy", 32'(busy), 32'd1);
      tick(1);
    end
    checkOutput("resp_ack", 32'(ack), 32'(exp_ack));
    checkOutput("resp_err", 32'(err), 32'(exp_err));
    tick(1);
    checkOutput("post_ack", 32'(ack), 32'd0);
    checkOutput("post_err", 32'(err), 32'd0);
    checkOutput("wait_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    req          = 3'b000;
    tgt          = 6'b000000;

    // Basic switch of requester 0 to clk2 with full settle.
    doReset();
    applyStimulus(3'b001, 6'b000001);
    runSwitch(2'd0, 2'b01, 3'b001, 3'b000, 1'b1);
    applyStimulus(3'b000, 6'b000001);
    tick(1);
    checkOutput("drop_idle", 32'(busy), 32'd0);

    // Invalid target is rejected without touching sel_clk.
    doReset();
    applyStimulus(3'b010, 6'b001100);
    runSwitch(2'd1, 2'b00, 3'b000, 3'b010, 1'b0);
    applyStimulus(3'b000, 6'b001100);
    tick(1);
    checkOutput("err_idle", 32'(busy), 32'd0);

    // All three requesting: round-robin order 0,1,2 from reset.
    doReset();
    applyStimulus(3'b111, 6'b001001);
    runSwitch(2'd0, 2'b01, 3'b001, 3'b000, 1'b1);
    applyStimulus(3'b110, 6'b001001);
    tick(1);
    checkOutput("rr_idle0", 32'(busy), 32'd0);
    runSwitch(2'd1, 2'b10, 3'b010, 3'b000, 1'b1);
    applyStimulus(3'b100, 6'b001001);
    tick(1);
    checkOutput("rr_idle1", 32'(busy), 32'd0);
    runSwitch(2'd2, 2'b00, 3'b100, 3'b000, 1'b1);
    applyStimulus(3'b000, 6'b001001);
    tick(1);

    // Same-target request acks at E1 with no settle.
    doReset();
    applyStimulus(3'b100, 6'b100000);
    runSwitch(2'd2, 2'b10, 3'b100, 3'b000, 1'b1);
    applyStimulus(3'b000, 6'b100000);
    tick(1);
    applyStimulus(3'b100, 6'b100000);
    runSwitch(2'd2, 2'b10, 3'b100, 3'b000, 1'b0);

    // Holding req after ack keeps WAIT_DROP; a competing request is not granted meanwhile.
    applyStimulus(3'b101, 6'b100000);
    tick(5);
    checkOutput("hold_busy", 32'(busy), 32'd1);
    checkOutput("hold_lg", 32'(last_grant), 32'd2);
    checkOutput("hold_ack", 32'(ack), 32'd0);
    applyStimulus(3'b001, 6'b100000);
    tick(1);
    checkOutput("hold_exit", 32'(busy), 32'd0);
    tick(1);
    checkOutput("hold_regrant", 32'(last_grant), 32'd0);
    applyStimulus(3'b000, 6'b100000);
    tick(12);

    // Reset during SETTLE aborts, then the held request is granted again.
    doReset();
    applyStimulus(3'b001, 6'b000001);
    tick(2);
    checkOutput("abort_sel_pre", 32'(sel_clk), 32'd1);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    checkOutput("abort_sel", 32'(sel_clk), 32'd0);
    checkOutput("abort_ack", 32'(ack), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    runSwitch(2'd0, 2'b01, 3'b001, 3'b000, 1'b1);
    applyStimulus(3'b000, 6'b000001);
    tick(1);

    // Request dropped mid-settle still completes; WAIT_DROP exits on the following edge.
    applyStimulus(3'b001, 6'b000010);
    tick(2);
    checkOutput("drop_sel", 32'(sel_clk), 32'd2);
    applyStimulus(3'b000, 6'b000010);
    tick(SETTLE_CYC - 1);
    tick(1);
    checkOutput("drop_ack", 32'(ack), 32'd1);
    tick(1);
    checkOutput("drop_wait", 32'(busy), 32'd1);
    tick(1);
    checkOutput("drop_exit", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clk_sel_ctrl.md
CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

Interface
REQ-001 SHALL provide parameter SETTLE_CYC, default 8, number of clk1 cycles sel_clk is held before a switch is acknowledged; legal range 1..15.
REQ-002 SHALL provide clk1  input  1  controller clock; all logic on rising edge.
REQ-003 SHALL provide rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide req  input  3  level requests from requesters 0..2; held high until ack/err.
REQ-005 SHALL provide tgt  input  6  requested clock per requester, {tgt2,tgt1,tgt0}; 00=clk1, 01=clk2, 10=clk3, 11=invalid.
REQ-006 SHALL provide sel_clk  output  2  registered select driven to the clock switch.
REQ-007 SHALL provide ack  output  3  one-hot one-cycle pulse, switch completed for that requester.
REQ-008 SHALL provide err  output  3  one-hot one-cycle pulse, request rejected (tgt=11).
REQ-009 SHALL provide busy  output  1  high whenever FSM is not IDLE.
REQ-010 SHALL provide last_grant  output  2  index (0..2) of the most recently granted requester.

Function
REQ-011 SHALL implement FSM states IDLE, CHECK, SETTLE, RESP, WAIT_DROP; all outputs registered.
REQ-012 IDLE: at an edge with req!=0, SHALL latch the winner into last_grant and go to CHECK; req=0 stays IDLE.
REQ-013 Arbitration SHALL be round-robin: priority order starts at (last_grant+1) mod 3, wrapping 2->0.
REQ-014 CHECK with tgt[winner]=11: SHALL go to RESP with err selected; sel_clk unchanged.
REQ-015 CHECK with tgt[winner]=sel_clk: SHALL go to RESP with ack selected; no settle wait.
REQ-016 CHECK otherwise: SHALL load sel_clk<=tgt[winner], counter<=SETTLE_CYC-1, go to SETTLE.
REQ-017 SETTLE: SHALL decrement counter each cycle; at counter=0 go to RESP, so SETTLE lasts exactly SETTLE_CYC cycles.
REQ-018 RESP: ack[winner] or err[winner] SHALL be high for exactly this one cycle, then go to WAIT_DROP.
REQ-019 WAIT_DROP: SHALL stay until req[winner]=0, then go to IDLE; other requests are not sampled meanwhile.
REQ-020 Latency: req sampled at edge E0; sel_clk changes at E1; ack high from E1+SETTLE_CYC to E1+SETTLE_CYC+1.
REQ-021 Same-target or invalid request: ack/err high from E1 to E2.
REQ-022 If req[winner] drops during CHECK or SETTLE, the switch SHALL complete, ack SHALL still pulse, and WAIT_DROP SHALL exit on the next edge.
REQ-023 tgt changes after E0 SHALL be ignored until CHECK samples it; CHECK samples tgt at E1 only.
REQ-024 ack and err SHALL never be simultaneously nonzero, and each SHALL be at most one-hot.

Reset
REQ-025 With rst_n=0 at an edge, SHALL force state=IDLE, sel_clk=00, ack=000, err=000, busy=0, last_grant=2, counter=0.
REQ-026 Reset mid-SETTLE or mid-RESP SHALL abort the operation with no ack/err pulse; the request is re-arbitrated after reset if still high.
REQ-027 After reset release, requester 0 SHALL have highest priority.

Verification
REQ-028 Reset then req=001, tgt0=01, SETTLE_CYC=8 -> sel_clk=01 at E1, ack=001 for one cycle at E9, busy high E0..WAIT_DROP exit.
REQ-029 req=111 held, tgts 01/10/00, each dropped after its ack -> grant order 0,1,2, last_grant 0,1,2, sel_clk 01,10,00.
REQ-030 req=010, tgt1=11 -> err=010 one cycle at E1, sel_clk unchanged at 00, ack stays 000.
REQ-031 sel_clk=10, req=100, tgt2=10 -> ack=100 at E1, no SETTLE state entered, sel_clk stays 10.
REQ-032 rst_n low for one edge during SETTLE of a switch to 01 -> sel_clk=00, ack=000, busy=0 next cycle; request re-granted if held.
REQ-033 Requester holds req after ack for 5 cycles -> FSM stays WAIT_DROP, no second grant; IDLE one edge after drop.
